commit_scoreboard: RTL and testbench
====================================

// Module: commit_scoreboard
// PURPOSE
//  Register busy-tracker: the issue-side counterpart of the commit unit's single write port.
//  Marks destination registers busy when an instruction issues to an execution unit.
//  Clears them when the commit unit presents that register number on its write port.
//  Holds issue (RAW/WAW hazard stall) until every source and destination of the candidate is free.
// PARAMETERS
//  NUM_REGS  64  architectural registers tracked; r0 is hard-wired, never busy
//  RN_W      6   register-number width, = clog2(NUM_REGS)
//  LINK_RN   63  register the branch unit always commits to (link/PC result)
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     asynchronous active-low reset
//  issue_valid     in   1     candidate instruction present at issue
//  issue_rs1       in   RN_W  source 1 (0 = none)
//  issue_rs2       in   RN_W  source 2 (0 = none)
//  issue_rs3       in   RN_W  source 3 (0 = none)
//  issue_rd1       in   RN_W  destination 1 (0 = none)
//  issue_rd2       in   RN_W  destination 2 (0 = none; advint second result)
//  issue_is_branch in   1     candidate is a branch: LINK_RN is an implicit destination
//  issue_ready     out  1     no hazard; issue fires when issue_valid & issue_ready
//  commit_rn       in   RN_W  commit write_rn; nonzero = a write completes this cycle
//  flush           in   1     synchronous clear of all busy state (pipeline flush)
//  busy_vec        out  NUM_REGS  per-register busy bits, bit 0 always 0
//  busy_count      out  RN_W+1  number of busy registers
//  drained         out  1     busy_count == 0
// BEHAVIOUR
//  Clocking/reset
//  - Single clock domain. Reset is asynchronous, active-low.
//  - Reset: busy_vec=0, busy_count=0, drained=1, issue_ready=1.
//  State
//  - busy[NUM_REGS-1:1] flops. busy_count is a registered counter kept equal to popcount(busy).
//  Hazard check (combinational from registered busy only; no same-cycle bypass of commit_rn)
//  - issue_ready = ~|{busy[rs1],busy[rs2],busy[rs3],busy[rd1],busy[rd2],
//    issue_is_branch & busy[LINK_RN]}.
//  - Index 0 always reads not-busy.
//  - issue_ready does not depend on issue_valid.
//  - Upstream holds all issue_* stable while issue_valid & ~issue_ready.
//  Update rules, per register r != 0, at the clock edge
//  - set(r) = issue_valid & issue_ready & (r==rd1 | r==rd2 | (issue_is_branch & r==LINK_RN)).
//  - clr(r) = (commit_rn == r).
//  - Priority: flush clears all > set > clr.
//    Set beats clr on the same register in the same cycle: the new producer wins.
//  - rd1==rd2, or rd equal to LINK_RN on a branch, sets one bit once; it counts once.
//  - commit_rn to a non-busy register is ignored, with no counter change.
//    The commit unit may present the same rn on consecutive cycles.
//  - commit_rn==0 means idle commit; no effect.
//  Latency
//  - Fire at edge N: the register reads busy and blocks dependents from cycle N+1.
//  - Commit at edge N: the register is free and issue_ready can rise in cycle N+1.
//    This gives one bubble minimum between producer commit and dependent issue.
//  busy_count
//  - next = count + (#newly set bits) - (#cleared bits that were busy and not re-set).
//  - Max NUM_REGS-1; never wraps.
//  - On flush: 0.
//  - drained is a registered compare of the next count.
//  Flush
//  - Takes effect at the edge. An issue fire in the same cycle is discarded (no bits set).
//  - Commits arriving after a flush hit non-busy registers and are ignored.
//  Reset mid-operation: immediate async clear to the reset values above.
// TESTING
//  1 Reset -> busy_vec=0, busy_count=0, drained=1, issue_ready=1 with all fields 0.
//  2 Issue rd1=5 at cycle 0; next cycle rs1=5 -> issue_ready=0.
//    commit_rn=5 at cycle 3 -> issue_ready=1 at cycle 4, busy_count back to 0.
//  3 Advint issue rd1=7, rd2=9 -> busy_count=2.
//    commit_rn=9 then 7 -> counts 1, then 0, then drained=1.
//    Candidate with rd1=7 stalls until 7 clears (WAW).
//  4 Branch issue (rd1=0, issue_is_branch=1) -> busy[63]=1.
//    Repeat commit_rn=63 on two consecutive cycles -> cleared once, count never negative.
//  5 Register 12 busy; commit_rn=12 and a fire setting rd1=12 on the same edge.
//    Fire is allowed only if 12 is not busy, so first free it, then force the set/clr collision.
//    -> busy[12]=1, count unchanged.
//  6 Five registers busy, flush together with a firing issue of rd1=3
//    -> all busy=0, count=0, busy[3]=0.
//    Assert rst_n low mid-sequence -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/commit_scoreboard_if.sv
// Issue/commit/status bundle between the issue stage and the register busy-tracker.
// Latency: wires only; timing is owned by the scoreboard.
// Backpressure: issue_ready stalls issue; commit_rn and flush are never stalled.
interface commit_scoreboard_if #(
  parameter int NUM_REGS = 64,
  parameter int RN_W     = 6
);
  logic                issue_valid;
  logic [RN_W-1:0]     issue_rs1;
  logic [RN_W-1:0]     issue_rs2;
  logic [RN_W-1:0]     issue_rs3;
  logic [RN_W-1:0]     issue_rd1;
  logic [RN_W-1:0]     issue_rd2;
  logic                issue_is_branch;
  logic                issue_ready;
  logic [RN_W-1:0]     commit_rn;
  logic                flush;
  logic [NUM_REGS-1:0] busy_vec;
  logic [RN_W:0]       busy_count;
  logic                drained;

  // Issue stage / commit unit side.
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs3, issue_rd1, issue_rd2,
           issue_is_branch, commit_rn, flush,
    input  issue_ready, busy_vec, busy_count, drained
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs3, issue_rd1, issue_rd2,
           issue_is_branch, commit_rn, flush,
    output issue_ready, busy_vec, busy_count, drained
  );
endinterface

// File: rtl/commit_scoreboard.sv
// Register busy-tracker: sets destinations busy on issue, clears them on commit writes.
// Latency: a fire or commit at edge N is visible in busy_vec/issue_ready from cycle N+1.
// Backpressure: issue_ready drops while any source/destination of the candidate is busy.
module commit_scoreboard #(
  parameter int NUM_REGS = 64,
  parameter int RN_W     = 6,
  parameter int LINK_RN  = 63
) (
  input  logic            clk,
  input  logic            rst_n,
  commit_scoreboard_if.slave sb
);
  localparam int CW = RN_W + 1;
  localparam logic [RN_W-1:0] LINK_IDX = RN_W'(LINK_RN);

  // Bit 0 of busy_q is never written to 1, so register 0 always reads free.
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec, newly_set, freed;
  logic [CW-1:0]       busy_count_q, busy_count_d, inc;
  logic                drained_q, drained_d;
  logic                hazard, fire, dec;

  // Hazard check reads registered busy state only; a same-cycle commit does not bypass.
  always_comb begin
    hazard = busy_q[sb.issue_rs1] | busy_q[sb.issue_rs2] | busy_q[sb.issue_rs3] |
             busy_q[sb.issue_rd1] | busy_q[sb.issue_rd2] |
             (sb.issue_is_branch & busy_q[LINK_IDX]);
    fire   = sb.issue_valid & ~hazard;
  end

  // Next busy state and counter: flush beats set, set beats clear on the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    inc     = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      set_vec[r] = fire & ((sb.issue_rd1 == RN_W'(r)) | (sb.issue_rd2 == RN_W'(r)) |
                           (sb.issue_is_branch & (LINK_IDX == RN_W'(r))));
      clr_vec[r] = (sb.commit_rn == RN_W'(r));
    end
    // Duplicate destinations collapse into one bit, so counting bits counts them once.
    newly_set = set_vec & ~busy_q;
    // Only a busy, not re-set register decrements; repeated commits to a free one do nothing.
    freed     = busy_q & clr_vec & ~set_vec;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = inc + CW'(newly_set[r]);
    end
    dec = |freed;
    if (sb.flush) begin
      busy_d       = '0;
      busy_count_d = '0;
    end else begin
      busy_d       = (busy_q & ~clr_vec) | set_vec;
      busy_count_d = busy_count_q + inc - CW'(dec);
    end
    busy_d[0] = 1'b0;
    drained_d = (busy_count_d == '0);
  end

  // State registers; reset leaves everything free and drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      drained_q    <= 1'b1;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      drained_q    <= drained_d;
    end
  end

  assign sb.issue_ready = ~hazard;
  assign sb.busy_vec    = busy_q;
  assign sb.busy_count  = busy_count_q;
  assign sb.drained     = drained_q;
endmodule

// File: tb/tb_commit_scoreboard.sv
// Bench for commit_scoreboard: directed scenarios plus randomized traffic vs a register-array model.
// Latency: model updates at each edge; outputs sampled at negedge (ready) and edge+1 (state).
// Backpressure: stimulus holds the candidate stable while it is stalled.
module tb_commit_scoreboard;
  localparam int NR   = 64;
  localparam int RW   = 6;
  localparam int LINK = 63;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  commit_scoreboard_if #(.NUM_REGS(NR), .RN_W(RW)) sbi();
  commit_scoreboard #(.NUM_REGS(NR), .RN_W(RW), .LINK_RN(LINK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sbi)
  );

  int checks = 0;
  int errors = 0;
  bit mbusy [NR];
  bit exp_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !(mbusy[sbi.issue_rs1] || mbusy[sbi.issue_rs2] || mbusy[sbi.issue_rs3] ||
             mbusy[sbi.issue_rd1] || mbusy[sbi.issue_rd2] ||
             (sbi.issue_is_branch && mbusy[LINK]));
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  // Commit frees first, then a firing issue marks its destinations: the new producer wins.
  task automatic model_update(input bit rdy);
    if (sbi.flush) begin
      for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
    end else begin
      if (sbi.commit_rn != 0) mbusy[sbi.commit_rn] = 1'b0;
      if (sbi.issue_valid && rdy) begin
        if (sbi.issue_rd1 != 0) mbusy[sbi.issue_rd1] = 1'b1;
        if (sbi.issue_rd2 != 0) mbusy[sbi.issue_rd2] = 1'b1;
        if (sbi.issue_is_branch) mbusy[LINK] = 1'b1;
      end
    end
  endtask

  task automatic check_state();
    int n;
    n = model_count();
    chk("busy_vec", sbi.busy_vec, model_vec());
    chk("busy_count", 64'(sbi.busy_count), 64'(n));
    chk("drained", 64'(sbi.drained), 64'(n == 0));
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rs3,
                       input int rd1, input int rd2, input bit br, input int crn, input bit fl);
    sbi.issue_valid     = v;
    sbi.issue_rs1       = RW'(rs1);
    sbi.issue_rs2       = RW'(rs2);
    sbi.issue_rs3       = RW'(rs3);
    sbi.issue_rd1       = RW'(rd1);
    sbi.issue_rd2       = RW'(rd2);
    sbi.issue_is_branch = br;
    sbi.commit_rn       = RW'(crn);
    sbi.flush           = fl;
  endtask

  // One clock: check ready mid-cycle, advance the model at the edge, check state just after.
  task automatic cycle();
    @(negedge clk);
    exp_rdy = model_ready();
    chk("issue_ready", 64'(sbi.issue_ready), 64'(exp_rdy));
    @(posedge clk);
    model_update(exp_rdy);
    #1;
    check_state();
  endtask

  function automatic int pick_reg();
    int k = $urandom_range(0, 9);
    if (k < 3) return 0;
    if (k == 9) return LINK;
    return $urandom_range(1, 15);
  endfunction

  task automatic random_run(input int n);
    bit held;
    int q [$];
    int crn;
    for (int c = 0; c < n; c++) begin
      held = sbi.issue_valid && !exp_rdy && !sbi.flush;
      q.delete();
      for (int i = 1; i < NR; i++) if (mbusy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) crn = q[$urandom_range(0, q.size() - 1)];
      else crn = pick_reg();
      if (held) begin
        sbi.commit_rn = RW'(crn);
        sbi.flush     = ($urandom_range(0, 39) == 0);
      end else begin
        drive($urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(), pick_reg(),
              pick_reg(), $urandom_range(0, 4) == 0, crn, $urandom_range(0, 39) == 0);
      end
      cycle();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    exp_rdy = 1'b1;
    for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    // Reset values while still in reset.
    chk("rst_busy_vec", sbi.busy_vec, 64'h0);
    chk("rst_busy_count", 64'(sbi.busy_count), 64'd0);
    chk("rst_drained", 64'(sbi.drained), 64'd1);
    chk("rst_issue_ready", 64'(sbi.issue_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW: producer of r5, dependent stalls until the commit, one bubble after it.
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0); cycle();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    chk("raw_stall", 64'(exp_rdy), 64'd0);
    sbi.commit_rn = 6'd5; cycle();
    sbi.commit_rn = 6'd0; cycle();
    chk("raw_release", 64'(exp_rdy), 64'd1);
    chk("raw_count", 64'(sbi.busy_count), 64'd0);

    // Dual destination, then a WAW candidate on r7.
    drive(1, 0, 0, 0, 7, 9, 0, 0, 0); cycle();
    chk("dual_count", 64'(sbi.busy_count), 64'd2);
    drive(1, 0, 0, 0, 7, 0, 0, 9, 0); cycle();
    chk("dual_after9", 64'(sbi.busy_count), 64'd1);
    sbi.commit_rn = 6'd7; cycle();
    chk("waw_stall", 64'(exp_rdy), 64'd0);
    chk("dual_drained", 64'(sbi.drained), 64'd1);
    sbi.commit_rn = 6'd0; cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0); cycle();

    // Branch implicit link destination, duplicated commit of the link register.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("link_busy", 64'(sbi.busy_vec[LINK]), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, LINK, 0); cycle(); cycle();
    chk("link_twice_count", 64'(sbi.busy_count), 64'd0);
    // Branch whose rd1 is the link register counts once.
    drive(1, 0, 0, 0, LINK, LINK, 1, 0, 0); cycle();
    chk("link_dup_count", 64'(sbi.busy_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, LINK, 0); cycle();

    // Set/clear collision on r12: the new producer keeps it busy.
    drive(1, 0, 0, 0, 12, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 12, 0); cycle();
    drive(1, 0, 0, 0, 12, 0, 0, 12, 0); cycle();
    chk("collide_busy12", 64'(sbi.busy_vec[12]), 64'd1);
    chk("collide_count", 64'(sbi.busy_count), 64'd1);

    // Five busy, flush with a firing issue of r3.
    drive(1, 0, 0, 0, 1, 2, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 4, 8, 0, 0, 0); cycle();
    chk("five_count", 64'(sbi.busy_count), 64'd5);
    drive(1, 0, 0, 0, 3, 0, 0, 0, 1); cycle();
    chk("flush_busy3", 64'(sbi.busy_vec[3]), 64'd0);
    chk("flush_count", 64'(sbi.busy_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 4, 0); cycle();

    random_run(400);

    // Asynchronous reset mid-cycle with state pending.
    drive(1, 0, 0, 0, 10, 11, 1, 0, 0); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
    chk("arst_busy_vec", sbi.busy_vec, 64'h0);
    chk("arst_busy_count", 64'(sbi.busy_count), 64'd0);
    chk("arst_drained", 64'(sbi.drained), 64'd1);
    chk("arst_issue_ready", 64'(sbi.issue_ready), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    random_run(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
